// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential 32-tap FIR filter with one multiply-accumulate per clock and a circular sample buffer.
// Define FIR_MAC_ROUND_EN to round half-up at the output instead of truncating.
module fir_mac_seq #(
    parameter int unsigned NTAPS = 32,
    parameter int unsigned SHIFT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [4:0]  coef_addr,
    input  logic [15:0] coef_data,
    output logic [15:0] dout,
    output logic        dout_valid
);

    localparam int unsigned AW   = 5;
    localparam int unsigned ACCW = 37;
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);
`ifdef FIR_MAC_ROUND_EN
    localparam logic signed [ACCW-1:0] RND = ACCW'(1) << (SHIFT - 1);
`else
    localparam logic signed [ACCW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    logic [15:0]              sbuf [NTAPS];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            k;
    logic [AW-1:0]            rd_ptr;
    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   acc_adj;
    logic signed [ACCW-1:0]   acc_sh;
    logic signed [31:0]       sample;
    logic signed [31:0]       coef;
    logic signed [31:0]       prod;
    logic [15:0]              sat;

    always_comb begin
        din_ready = (state == IDLE);
        coef_addr = (state == MAC) ? k : '0;
        // wr_ptr already points past the newest sample, hence the extra -1
        rd_ptr    = wr_ptr - AW'(1) - k;
        sample    = 32'($signed(sbuf[rd_ptr]));
        coef      = 32'($signed(coef_data));
        prod      = sample * coef;
        acc_adj   = acc + RND;
        acc_sh    = acc_adj >>> SHIFT;
        if (acc_sh > SAT_MAX) begin
            sat = 16'h7FFF;
        end else if (acc_sh < SAT_MIN) begin
            sat = 16'h8000;
        end else begin
            sat = acc_sh[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            wr_ptr     <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sbuf       <= '{default: '0};
        end else begin
            dout_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (din_valid) begin
                        sbuf[wr_ptr] <= din;
                        wr_ptr       <= wr_ptr + AW'(1);
                        acc          <= '0;
                        k            <= '0;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    k   <= k + AW'(1);
                    if (k == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    dout       <= sat;
                    dout_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameter NTAPS, 32, number of taps; coefficient address width is 5 bits.
REQ-002 Parameter SHIFT, 15, arithmetic right shift applied to the accumulator (Q15 coefficients).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  16  signed two's-complement input sample.
REQ-006 din_valid  input  1  din is presented this cycle.
REQ-007 din_ready  output  1  block accepts a sample this cycle; combinational, high exactly when the state is IDLE.
REQ-008 coef_addr  output  5  tap index driven to the combinational coefficient ROM.
REQ-009 coef_data  input  16  signed coefficient h[coef_addr], valid in the same cycle as coef_addr.
REQ-010 dout  output  16  signed filter output, registered.
REQ-011 dout_valid  output  1  one-cycle pulse qualifying dout.

Function
REQ-012 FSM states: IDLE, MAC, DONE.
- IDLE -> MAC on din_valid && din_ready.
- MAC -> DONE on the edge where k==31.
- DONE -> IDLE unconditionally.
REQ-013 Acceptance edge:
- writes din into a 32-entry circular sample buffer at wr_ptr;
- advances wr_ptr modulo 32;
- clears the 37-bit accumulator;
- clears tap counter k to 0.
REQ-014 In MAC, coef_addr = k, and the sample operand is the buffer entry written k acceptances ago (k=0 is the newest sample); pointer arithmetic wraps modulo 32.
REQ-015 Each MAC edge:
- acc <= acc + sext(sample * coef_data), with a signed 16x16 -> 32-bit product sign-extended to 37 bits;
- k <= k + 1.
- No intermediate overflow is possible.
REQ-016 The DONE edge registers dout <= sat16(acc >>> SHIFT) and sets dout_valid to 1. dout_valid clears on the next edge.
REQ-017 Saturation: results above 32767 give 16'h7FFF; results below -32768 give 16'h8000.
REQ-018 Latency and throughput:
- dout_valid is high in the cycle following the 33rd edge after the acceptance edge.
- Throughput is one sample per 34 cycles.
- dout holds its value until the next DONE.
REQ-019 coef_addr is 0 in IDLE and DONE.
REQ-020 din_valid while din_ready is low is ignored. The sample is not captured; the source holds it.
REQ-021 dout_valid and din_ready may both be high in the same cycle. A sample accepted in that cycle starts a new pass, and the pulse is still delivered.
REQ-022 Buffer contents persist between samples; unwritten entries contribute zero.

Reset
REQ-023 Assertion of rst_n low, asynchronous and at any time including mid-MAC, forces:
- state IDLE, k=0, wr_ptr=0, acc=0;
- all 32 buffer entries 0;
- dout=16'h0000, dout_valid=0;
- hence din_ready=1 and coef_addr=0.
REQ-024 A pass interrupted by reset produces no output. The first acceptance after reset behaves as after power-up.

Configuration
REQ-025 Macro FIR_MAC_ROUND_EN:
- Defined: DONE computes sat16((acc + 2^(SHIFT-1)) >>> SHIFT), i.e. round-half-up.
- Undefined: truncation toward negative infinity as in REQ-016.
- Latency, handshake and saturation are identical in both builds.

Verification
REQ-026 Impulse: reset, then one sample 16'h4000 followed by zeros, with a bench ROM holding h[1]=16'h0011, h[15]=16'h4E86 and h[16]=16'hB17A.
- Truncating build: outputs 2, 16 and 17 are 8, 10051 and -10051 (16'hD8BD).
- FIR_MAC_ROUND_EN build: output 2 is 9, outputs 16 and 17 are unchanged.
REQ-027 Timing: accept a sample at edge E -> coef_addr steps 0..31 over the 32 MAC cycles, dout_valid is high exactly one cycle after edge E+33, and din_ready is low from E+1 through E+33.
REQ-028 Saturation: ROM all 16'h7FFF.
- 32 samples of 16'h7FFF -> final dout 16'h7FFF.
- 32 samples of 16'h8000 -> final dout 16'h8000.
REQ-029 Back-pressure: hold din_valid high continuously -> exactly one acceptance every 34 cycles, and no sample is captured while din_ready=0.
REQ-030 Reset mid-MAC: assert rst_n low at k=10, then release and send the REQ-026 impulse -> no dout_valid from the aborted pass, and outputs are identical to REQ-026.
